// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM types: measurement FSM states and default counter width
package pwm_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchroniser with registered previous level and edge strobes
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              s_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      s_d    <= sync_q[STAGES-1];
    end
  end

  assign s    = sync_q[STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - measures high time and rise-to-rise period of an async PWM input
module pulse_width_meter
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             signal_in,
  input  logic             meas_ready,
  input  logic             clr_flags,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_period,
  output logic             sat_flag,
  output logic             overrun_flag
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic       s_level_unused;
  logic       rise;
  logic       fall;
  pwm_state_t state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] lo_q, lo_d;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] period_c;
  logic             done;
  logic             sat_set;
  logic             overrun_set;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (signal_in),
    .s     (s_level_unused),
    .rise  (rise),
    .fall  (fall)
  );

  // Period is formed one bit wider so an overflow can be detected and clamped.
  assign sum      = {1'b0, hi_q} + {1'b0, lo_q};
  assign period_c = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done    = 1'b0;
    sat_set = 1'b0;
    if (!en) begin
      state_d = IDLE;
      hi_d    = '0;
      lo_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          hi_d = '0;
          lo_d = '0;
          if (rise) begin
            state_d = HIGH;
            hi_d    = CNT_ONE;
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            lo_d    = CNT_ONE;
          end else if (hi_q == CNT_MAX) begin
            sat_set = 1'b1;
          end else begin
            hi_d = hi_q + 1'b1;
          end
        end
        LOW: begin
          // A rise both completes this pulse and starts the next one.
          if (rise) begin
            done    = 1'b1;
            sat_set = sum[CNT_W];
            state_d = HIGH;
            hi_d    = CNT_ONE;
            lo_d    = '0;
          end else if (lo_q == CNT_MAX) begin
            sat_set = 1'b1;
          end else begin
            lo_d = lo_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          hi_d    = '0;
          lo_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign overrun_set = done & meas_valid & ~meas_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meas_valid   <= 1'b0;
      meas_high    <= '0;
      meas_period  <= '0;
      sat_flag     <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      if (done && (!meas_valid || meas_ready)) begin
        meas_valid  <= 1'b1;
        meas_high   <= hi_q;
        meas_period <= period_c;
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
      sat_flag     <= sat_set | (sat_flag & ~clr_flags);
      overrun_flag <= overrun_set | (overrun_flag & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - directed self-checking bench for pulse_width_meter
module tb_pulse_width_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        signal_in = 1'b0;
  logic        meas_ready = 1'b1;
  logic        clr_flags = 1'b0;
  logic        meas_valid;
  logic [15:0] meas_high;
  logic [15:0] meas_period;
  logic        sat_flag;
  logic        overrun_flag;

  logic        sig8 = 1'b0;
  logic        valid8;
  logic [7:0]  high8;
  logic [7:0]  period8;
  logic        sat8;
  logic        overrun8;

  int vectors = 0;
  int miscompares = 0;
  int qh[$];
  int qp[$];
  int q8h[$];
  int q8p[$];

  pulse_width_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .signal_in    (signal_in),
    .meas_ready   (meas_ready),
    .clr_flags    (clr_flags),
    .meas_valid   (meas_valid),
    .meas_high    (meas_high),
    .meas_period  (meas_period),
    .sat_flag     (sat_flag),
    .overrun_flag (overrun_flag)
  );

  pulse_width_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .signal_in    (sig8),
    .meas_ready   (1'b1),
    .clr_flags    (clr_flags),
    .meas_valid   (valid8),
    .meas_high    (high8),
    .meas_period  (period8),
    .sat_flag     (sat8),
    .overrun_flag (overrun8)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (meas_valid && meas_ready) begin
      qh.push_back(int'(meas_high));
      qp.push_back(int'(meas_period));
    end
    if (valid8) begin
      q8h.push_back(int'(high8));
      q8p.push_back(int'(period8));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int h, input int l);
    signal_in = 1'b1;
    tick(h);
    signal_in = 1'b0;
    tick(l);
  endtask

  task automatic restart();
    signal_in = 1'b0;
    en = 1'b0;
    tick(4);
    en = 1'b1;
    tick(2);
    qh.delete();
    qp.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    vectors++; if (meas_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", meas_valid); end
    vectors++; if (meas_high !== 16'd0) begin miscompares++; $display("FAIL reset_high got %0d want 0", meas_high); end
    vectors++; if (meas_period !== 16'd0) begin miscompares++; $display("FAIL reset_period got %0d want 0", meas_period); end
    vectors++; if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL reset_sat got %0b want 0", sat_flag); end
    vectors++; if (overrun_flag !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %0b want 0", overrun_flag); end
    vectors++; if (valid8 !== 1'b0) begin miscompares++; $display("FAIL reset_valid8 got %0b want 0", valid8); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    meas_ready = 1'b1;
    restart();
    for (int i = 0; i < 3; i++) pulse(20, 30);
    vectors++; if (qh.size() !== 2) begin miscompares++; $display("FAIL basic_count got %0d want 2", qh.size()); end
    for (int i = 0; i < 2; i++) begin
      vectors++; if (qh[i] !== 20) begin miscompares++; $display("FAIL basic_high%0d got %0d want 20", i, qh[i]); end
      vectors++; if (qp[i] !== 50) begin miscompares++; $display("FAIL basic_period%0d got %0d want 50", i, qp[i]); end
    end
    vectors++; if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL basic_sat got %0b want 0", sat_flag); end
    vectors++; if (overrun_flag !== 1'b0) begin miscompares++; $display("FAIL basic_overrun got %0b want 0", overrun_flag); end
  endtask

  task automatic test_partial();
    meas_ready = 1'b1;
    en = 1'b0;
    signal_in = 1'b1;
    tick(5);
    qh.delete();
    qp.delete();
    en = 1'b1;
    tick(10);
    signal_in = 1'b0;
    tick(10);
    pulse(40, 10);
    pulse(40, 10);
    vectors++; if (qh.size() !== 1) begin miscompares++; $display("FAIL partial_count got %0d want 1", qh.size()); end
    vectors++; if (qh[0] !== 40) begin miscompares++; $display("FAIL partial_high got %0d want 40", qh[0]); end
    vectors++; if (qp[0] !== 50) begin miscompares++; $display("FAIL partial_period got %0d want 50", qp[0]); end
  endtask

  task automatic test_overrun();
    meas_ready = 1'b0;
    restart();
    for (int i = 0; i < 4; i++) pulse(7, 9);
    vectors++; if (meas_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid got %0b want 1", meas_valid); end
    vectors++; if (meas_high !== 16'd7) begin miscompares++; $display("FAIL ovr_high got %0d want 7", meas_high); end
    vectors++; if (meas_period !== 16'd16) begin miscompares++; $display("FAIL ovr_period got %0d want 16", meas_period); end
    vectors++; if (overrun_flag !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %0b want 1", overrun_flag); end
    vectors++; if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL ovr_sat got %0b want 0", sat_flag); end
    meas_ready = 1'b1;
    tick(1);
    meas_ready = 1'b0;
    vectors++; if (meas_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_drain got %0b want 0", meas_valid); end
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    vectors++; if (overrun_flag !== 1'b0) begin miscompares++; $display("FAIL ovr_clear got %0b want 0", overrun_flag); end
    meas_ready = 1'b1;
  endtask

  task automatic test_saturate();
    restart();
    q8h.delete();
    q8p.delete();
    sig8 = 1'b1;
    tick(300);
    sig8 = 1'b0;
    tick(10);
    sig8 = 1'b1;
    tick(5);
    sig8 = 1'b0;
    tick(5);
    vectors++; if (q8h.size() !== 1) begin miscompares++; $display("FAIL sat_count got %0d want 1", q8h.size()); end
    vectors++; if (q8h[0] !== 255) begin miscompares++; $display("FAIL sat_high got %0d want 255", q8h[0]); end
    vectors++; if (q8p[0] !== 255) begin miscompares++; $display("FAIL sat_period got %0d want 255", q8p[0]); end
    vectors++; if (sat8 !== 1'b1) begin miscompares++; $display("FAIL sat_flag got %0b want 1", sat8); end
  endtask

  task automatic test_async_reset();
    meas_ready = 1'b0;
    restart();
    pulse(10, 10);
    signal_in = 1'b1;
    tick(5);
    vectors++; if (meas_valid !== 1'b1) begin miscompares++; $display("FAIL rst_pre_valid got %0b want 1", meas_valid); end
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (meas_valid !== 1'b0) begin miscompares++; $display("FAIL rst_async_valid got %0b want 0", meas_valid); end
    vectors++; if (meas_high !== 16'd0) begin miscompares++; $display("FAIL rst_async_high got %0d want 0", meas_high); end
    vectors++; if (meas_period !== 16'd0) begin miscompares++; $display("FAIL rst_async_period got %0d want 0", meas_period); end
    tick(1);
    signal_in = 1'b0;
    tick(3);
    reset = 1'b0;
    meas_ready = 1'b1;
    tick(3);
    qh.delete();
    qp.delete();
    pulse(12, 8);
    pulse(12, 8);
    tick(3);
    vectors++; if (qh.size() !== 1) begin miscompares++; $display("FAIL rst_count got %0d want 1", qh.size()); end
    vectors++; if (qh[0] !== 12) begin miscompares++; $display("FAIL rst_high got %0d want 12", qh[0]); end
    vectors++; if (qp[0] !== 20) begin miscompares++; $display("FAIL rst_period got %0d want 20", qp[0]); end
  endtask

  task automatic test_enable_gap();
    meas_ready = 1'b0;
    restart();
    pulse(6, 6);
    pulse(6, 6);
    signal_in = 1'b1;
    tick(6);
    signal_in = 1'b0;
    tick(4);
    en = 1'b0;
    tick(5);
    en = 1'b1;
    vectors++; if (meas_valid !== 1'b1) begin miscompares++; $display("FAIL en_held_valid got %0b want 1", meas_valid); end
    vectors++; if (meas_high !== 16'd6) begin miscompares++; $display("FAIL en_held_high got %0d want 6", meas_high); end
    vectors++; if (meas_period !== 16'd12) begin miscompares++; $display("FAIL en_held_period got %0d want 12", meas_period); end
    meas_ready = 1'b1;
    tick(4);
    pulse(9, 11);
    pulse(9, 11);
    tick(2);
    vectors++; if (qh.size() !== 2) begin miscompares++; $display("FAIL en_count got %0d want 2", qh.size()); end
    vectors++; if (qh[0] !== 6) begin miscompares++; $display("FAIL en_rec0_high got %0d want 6", qh[0]); end
    vectors++; if (qp[0] !== 12) begin miscompares++; $display("FAIL en_rec0_period got %0d want 12", qp[0]); end
    vectors++; if (qh[1] !== 9) begin miscompares++; $display("FAIL en_rec1_high got %0d want 9", qh[1]); end
    vectors++; if (qp[1] !== 20) begin miscompares++; $display("FAIL en_rec1_period got %0d want 20", qp[1]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_overrun();
    test_saturate();
    test_async_reset();
    test_enable_gap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
